// File: rtl/cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate data cache front end with 64-bit blocks.
// Define CACHE_STATS_EN to add saturating read hit/miss counters (hit_count, miss_count).
module cache_controller #(
    parameter int SET_BITS = 6,
    parameter int TAG_BITS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] ALU_Res,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        ready,
    output logic        sram_rd_en,
    output logic        sram_wr_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int SETS = 1 << SET_BITS;
    localparam int TAG_LO = SET_BITS + 3;
    localparam int TAG_HI = SET_BITS + TAG_BITS + 2;

    typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;

    state_t              state_q;
    logic                rd_req_q, wr_req_q;
    logic [SETS-1:0]     valid0_q, valid1_q, lru_q;
    logic [TAG_BITS-1:0] tag0_q [SETS];
    logic [TAG_BITS-1:0] tag1_q [SETS];
    logic [63:0]         data0_q [SETS];
    logic [63:0]         data1_q [SETS];

    logic [31:0]         addr_off;
    logic                word_sel;
    logic [SET_BITS-1:0] idx;
    logic [TAG_BITS-1:0] tag;
    logic                hit0, hit1, hit, hit_way, victim;
    logic [63:0]         hit_data;
    logic                rd_hit, wr_hit, fill;
    logic                addr_unused;

    // Data region starts at byte 1024; the offset wraps modulo 2**32.
    assign addr_off    = ALU_Res - 32'd1024;
    assign word_sel    = addr_off[2];
    assign idx         = addr_off[SET_BITS+2:3];
    assign tag         = addr_off[TAG_HI:TAG_LO];
    assign addr_unused = ^{addr_off[31:TAG_HI+1], addr_off[1:0]};

    assign hit0     = valid0_q[idx] && (tag0_q[idx] == tag);
    assign hit1     = valid1_q[idx] && (tag1_q[idx] == tag);
    assign hit      = hit0 || hit1;
    assign hit_way  = !hit0;
    assign hit_data = hit0 ? data0_q[idx] : data1_q[idx];
    // An empty way is always filled before an LRU eviction, way0 first.
    assign victim   = !valid0_q[idx] ? 1'b0 : (!valid1_q[idx] ? 1'b1 : lru_q[idx]);

    assign rd_hit = (state_q == IDLE) && rd_en && !wr_en && hit;
    assign wr_hit = (state_q == IDLE) && wr_en && hit;
    assign fill   = (state_q == RD_MISS) && sram_ready;

    assign sram_rd_en   = rd_req_q;
    assign sram_wr_en   = wr_req_q;
    assign sram_address = ALU_Res;
    assign sram_wdata   = writeData;

    always_comb begin
        ready    = 1'b1;
        readData = 32'd0;
        case (state_q)
            IDLE: begin
                if (wr_en) begin
                    ready = 1'b0;
                end else if (rd_en) begin
                    ready = hit;
                    if (hit) readData = word_sel ? hit_data[63:32] : hit_data[31:0];
                end
            end
            RD_MISS: begin
                ready = sram_ready;
                if (sram_ready) readData = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];
            end
            WR_THRU: ready = sram_ready;
            default: ready = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rd_req_q <= 1'b0;
            wr_req_q <= 1'b0;
            valid0_q <= '0;
            valid1_q <= '0;
            lru_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wr_en) begin
                        if (hit) lru_q[idx] <= ~hit_way;
                        wr_req_q <= 1'b1;
                        state_q  <= WR_THRU;
                    end else if (rd_en) begin
                        if (hit) begin
                            lru_q[idx] <= ~hit_way;
                        end else begin
                            rd_req_q <= 1'b1;
                            state_q  <= RD_MISS;
                        end
                    end
                end
                RD_MISS: begin
                    if (sram_ready) begin
                        if (victim) valid1_q[idx] <= 1'b1;
                        else        valid0_q[idx] <= 1'b1;
                        lru_q[idx] <= ~victim;
                        rd_req_q   <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                WR_THRU: begin
                    if (sram_ready) begin
                        wr_req_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag/data arrays carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (wr_hit) begin
            if (hit_way) begin
                if (word_sel) data1_q[idx][63:32] <= writeData;
                else          data1_q[idx][31:0]  <= writeData;
            end else begin
                if (word_sel) data0_q[idx][63:32] <= writeData;
                else          data0_q[idx][31:0]  <= writeData;
            end
        end
        if (fill) begin
            if (victim) begin
                tag1_q[idx]  <= tag;
                data1_q[idx] <= sram_rdata;
            end else begin
                tag0_q[idx]  <= tag;
                data0_q[idx] <= sram_rdata;
            end
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (rd_hit && (hit_count_q != 32'hFFFF_FFFF)) hit_count_d = hit_count_q + 32'd1;
        if (fill && (miss_count_q != 32'hFFFF_FFFF))  miss_count_d = miss_count_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: SRAM controller model plus a scoreboard-driven monitor.
module tb_cache_controller;

    logic        clk, rst, rd_en, wr_en;
    logic [31:0] ALU_Res, writeData, readData, sram_address, sram_wdata;
    logic        ready, sram_rd_en, sram_wr_en, sram_ready;
    logic [63:0] sram_rdata;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    cache_controller dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
        .ALU_Res(ALU_Res), .writeData(writeData), .readData(readData), .ready(ready),
        .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en), .sram_address(sram_address),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready)
`ifdef CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          miss;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [63:0] mem [int unsigned];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] blk(input logic [31:0] addr);
        logic [31:0] base;
        base = addr & 32'hFFFF_FFF8;
        if (mem.exists(base >> 3)) return mem[base >> 3];
        return {base + 32'd4, base};
    endfunction

    // SRAM controller model: ready low 5 cycles after the request appears, then high for 1 cycle.
    initial begin
        int cnt;
        logic [63:0] b;
        cnt = 0;
        sram_ready = 1'b0;
        sram_rdata = 64'd0;
        mem[32'h400 >> 3] = 64'h2222_2222_1111_1111;
        forever begin
            @(posedge clk);
            #1;
            if (sram_ready) begin
                sram_ready = 1'b0;
                cnt = 0;
            end else if (sram_rd_en || sram_wr_en) begin
                cnt++;
                if (cnt == 6) begin
                    if (sram_wr_en) begin
                        b = blk(sram_address);
                        if (sram_address[2]) b[63:32] = sram_wdata;
                        else                 b[31:0]  = sram_wdata;
                        mem[sram_address >> 3] = b;
                    end else begin
                        sram_rdata = blk(sram_address);
                    end
                    sram_ready = 1'b1;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: pops one expectation per completed request.
    initial begin
        int          stall;
        bit          saw_rd, saw_wr;
        logic [31:0] cap_addr, cap_wdata;
        exp_t        e;
        stall = 0; saw_rd = 0; saw_wr = 0; cap_addr = '0; cap_wdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 0; saw_rd = 0; saw_wr = 0;
            end else if (rd_en || wr_en) begin
                if (sram_rd_en || sram_wr_en) begin
                    cap_addr  = sram_address;
                    cap_wdata = sram_wdata;
                end
                if (sram_rd_en) saw_rd = 1;
                if (sram_wr_en) saw_wr = 1;
                if (!ready) begin
                    stall++;
                end else if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got completion at %h, expected none", ALU_Res);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("stall@%h", e.addr), 64'(stall), (e.is_wr || e.miss) ? 64'd6 : 64'd0);
                    chk($sformatf("sram_req@%h", e.addr), {62'd0, saw_rd, saw_wr},
                        e.is_wr ? 64'd1 : (e.miss ? 64'd2 : 64'd0));
                    if (e.is_wr) begin
                        chk($sformatf("wr_addr@%h", e.addr), {32'd0, cap_addr}, {32'd0, e.addr});
                        chk($sformatf("wr_data@%h", e.addr), {32'd0, cap_wdata}, {32'd0, e.wdata});
                    end else begin
                        chk($sformatf("rdata@%h", e.addr), {32'd0, readData}, {32'd0, e.rdata});
                        if (e.miss) chk($sformatf("rd_addr@%h", e.addr), {32'd0, cap_addr}, {32'd0, e.addr});
                    end
                    stall = 0; saw_rd = 0; saw_wr = 0;
                end
            end
        end
    end

    // Called at posedge+1; leaves the bus idle at the posedge+1 after completion.
    task automatic do_req(input bit w, input bit both, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input bit miss);
        exp_t e;
        bit   done;
        e.is_wr = w; e.addr = addr; e.wdata = wd; e.rdata = exp_rd; e.miss = miss;
        sb.push_back(e);
        ALU_Res = addr;
        writeData = wd;
        wr_en = w;
        rd_en = !w || both;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            done = ready;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout@%h: ready stayed 0, expected 1", addr);
            sb.delete();
        end
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; ALU_Res = 32'd0; writeData = 32'd0;
        repeat (2) @(negedge clk);
        chk("reset_ready", {63'd0, ready}, 64'd1);
        chk("reset_rdata", {32'd0, readData}, 64'd0);
        chk("reset_sram_en", {62'd0, sram_rd_en, sram_wr_en}, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        do_req(0, 0, 32'h400,  0, 32'h1111_1111, 1);
        do_req(0, 0, 32'h400,  0, 32'h1111_1111, 0);
        do_req(0, 0, 32'h404,  0, 32'h2222_2222, 0);
        do_req(0, 0, 32'h408,  0, 32'h0000_0408, 1);
        do_req(0, 0, 32'h600,  0, 32'h0000_0600, 1);
        do_req(0, 0, 32'h400,  0, 32'h1111_1111, 0);
        do_req(0, 0, 32'h800,  0, 32'h0000_0800, 1);
        do_req(0, 0, 32'h400,  0, 32'h1111_1111, 0);
        do_req(0, 0, 32'h600,  0, 32'h0000_0600, 1);
        do_req(0, 0, 32'h604,  0, 32'h0000_0604, 0);
        do_req(1, 0, 32'h400,  32'hDEAD_BEEF, 0, 0);
        do_req(0, 0, 32'h400,  0, 32'hDEAD_BEEF, 0);
        do_req(0, 0, 32'h404,  0, 32'h2222_2222, 0);
        do_req(1, 1, 32'h1000, 32'h1234_5678, 0, 0);
        do_req(0, 0, 32'h1000, 0, 32'h1234_5678, 1);
        do_req(0, 0, 32'h1004, 0, 32'h0000_1004, 0);
`ifdef CACHE_STATS_EN
        @(negedge clk);
        chk("hit_count", {32'd0, hit_count}, 64'd8);
        chk("miss_count", {32'd0, miss_count}, 64'd6);
        @(posedge clk);
        #1;
`endif

        // Abort a miss two cycles into RD_MISS.
        ALU_Res = 32'h1400;
        rd_en = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        rd_en = 1'b0;
        #1;
        chk("rst_sram_rd_en", {63'd0, sram_rd_en}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("post_rst_ready", {63'd0, ready}, 64'd1);
`ifdef CACHE_STATS_EN
        chk("rst_hit_count", {32'd0, hit_count}, 64'd0);
        chk("rst_miss_count", {32'd0, miss_count}, 64'd0);
`endif
        @(posedge clk);
        #1;
        do_req(0, 0, 32'h400, 0, 32'hDEAD_BEEF, 1);

        repeat (3) @(posedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
